// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state encodings, mode codes and bar colour table
package ov7670_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBP    = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFP    = 3'd4;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_GRAD  = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // RGB565 colour of each of the eight vertical bars, left to right
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_pattern.sv
// rtl/ov7670_pattern.sv - combinational test-pattern pixel generator
// Ports: mode (pattern select), x/y (0-based active coordinates),
//        solid (latched colour), rgb (RGB565 pixel out)
module ov7670_pattern
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [1:0]  mode,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] solid,
    output logic [15:0] rgb
);

    localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [15:0] BAR_W16 = 16'(BAR_W);

    logic [15:0] bar_idx;

    always_comb begin
        // pixels beyond 8*BAR_W (H_ACTIVE not a multiple of 8) stay in the last bar
        bar_idx = x / BAR_W16;
        if (bar_idx > 16'd7) begin
            bar_idx = 16'd7;
        end
        case (mode)
            MODE_GRAD:  rgb = x + y;
            MODE_SOLID: rgb = solid;
            MODE_BARS,
            MODE_RSVD:  rgb = bar_colour(bar_idx[2:0]);
            default:    rgb = bar_colour(bar_idx[2:0]);
        endcase
    end

endmodule

// File: rtl/ov7670_sensor_emu.sv
// rtl/ov7670_sensor_emu.sv - OV7670 camera output emulator (PCLK/VSYNC/HREF/D)
// Ports: clk100/reset (async high), enable (run request), mode/solid_rgb
//        (pattern, latched at frame start), ov_pclk/ov_vsync/ov_href/ov_d
//        (sensor bus), frame_done (one-cycle end-of-frame pulse)
module ov7670_sensor_emu
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 784,
    parameter int V_ACTIVE  = 480,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int V_TOTAL   = 510,
    parameter int PCLK_DIV  = 4
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        ov_pclk,
    output logic        ov_vsync,
    output logic        ov_href,
    output logic [7:0]  ov_d,
    output logic        frame_done
);

    localparam int HALF = PCLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW   = $clog2(2 * H_TOTAL + 1);
    localparam int LW   = $clog2(V_TOTAL + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(2 * H_TOTAL - 1);
    localparam logic [PW-1:0] HREF_END  = PW'(2 * H_ACTIVE);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);
    localparam logic [LW-1:0] VBP_START = LW'(VS_LINES);
    localparam logic [LW-1:0] ACT_START = LW'(VS_LINES + VBP_LINES);
    localparam logic [LW-1:0] VFP_START = LW'(VS_LINES + VBP_LINES + V_ACTIVE);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          first_q, first_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   solid_q, solid_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;

    logic [PW-1:0] nxt_pix;
    logic [LW-1:0] nxt_line;
    logic          frame_end;
    logic          pclk_fall;
    logic [15:0]   pat_x, pat_y, pix_rgb;

    function automatic logic [2:0] line_state(input logic [LW-1:0] l);
        if (l < VBP_START) return ST_VSYNC;
        if (l < ACT_START) return ST_VBP;
        if (l < VFP_START) return ST_ACTIVE;
        return ST_VFP;
    endfunction

    // Slot to present at the next PCLK fall. The first fall after leaving
    // IDLE presents slot 0 itself rather than advancing past it.
    always_comb begin
        nxt_pix   = pix_q;
        nxt_line  = line_q;
        frame_end = 1'b0;
        if (!first_q) begin
            if (pix_q != PIX_LAST) begin
                nxt_pix = pix_q + PW'(1);
            end else begin
                nxt_pix = '0;
                if (line_q != LINE_LAST) begin
                    nxt_line = line_q + LW'(1);
                end else begin
                    nxt_line  = '0;
                    frame_end = 1'b1;
                end
            end
        end
        pat_x = 16'(nxt_pix >> 1);
        pat_y = 16'(nxt_line - ACT_START);
    end

    ov7670_pattern #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .mode  (mode_q),
        .x     (pat_x),
        .y     (pat_y),
        .solid (solid_q),
        .rgb   (pix_rgb)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pclk_d    = pclk_q;
        first_d   = first_q;
        pix_d     = pix_q;
        line_d    = line_q;
        mode_d    = mode_q;
        solid_d   = solid_q;
        vsync_d   = vsync_q;
        href_d    = href_q;
        data_d    = data_q;
        done_d    = 1'b0;
        pclk_fall = 1'b0;

        if (state_q == ST_IDLE) begin
            div_d  = '0;
            pclk_d = 1'b0;
            if (enable) begin
                state_d = ST_VSYNC;
                pix_d   = '0;
                line_d  = '0;
                first_d = 1'b1;
                mode_d  = mode;
                solid_d = solid_rgb;
            end
        end else if (div_q == DIV_LAST) begin
            div_d     = '0;
            pclk_d    = ~pclk_q;
            pclk_fall = pclk_q;
        end else begin
            div_d = div_q + DW'(1);
        end

        // Bus outputs only move on the falling PCLK edge so they are settled
        // for the receiver's rising-edge capture.
        if (pclk_fall) begin
            first_d = 1'b0;
            pix_d   = nxt_pix;
            line_d  = nxt_line;
            done_d  = frame_end;
            if (frame_end && !enable) begin
                state_d = ST_IDLE;
                vsync_d = 1'b0;
                href_d  = 1'b0;
                data_d  = 8'h00;
            end else begin
                if (frame_end) begin
                    mode_d  = mode;
                    solid_d = solid_rgb;
                end
                state_d = line_state(nxt_line);
                vsync_d = (state_d == ST_VSYNC);
                href_d  = (state_d == ST_ACTIVE) && (nxt_pix < HREF_END);
                if (!href_d) begin
                    data_d = 8'h00;
                end else if (nxt_pix[0]) begin
                    data_d = pix_rgb[7:0];
                end else begin
                    data_d = pix_rgb[15:8];
                end
            end
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            first_q <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            first_q <= first_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ov_pclk    = pclk_q;
    assign ov_vsync   = vsync_q;
    assign ov_href    = href_q;
    assign ov_d       = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ov7670_sensor_emu.sv
// tb/tb_ov7670_sensor_emu.sv - self-checking bench for ov7670_sensor_emu
module tb_ov7670_sensor_emu;

    localparam int HA = 8, HT = 10, VA = 2, VS = 1, VBP = 1, VT = 5, PD = 4;
    localparam int LINE_SLOTS  = 2 * HT;
    localparam int FRAME_SLOTS = LINE_SLOTS * VT;
    localparam logic [15:0] BARS [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk100 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        ov_pclk, ov_vsync, ov_href, frame_done;
    logic [7:0]  ov_d;

    ov7670_sensor_emu #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .VS_LINES(VS),
        .VBP_LINES(VBP), .V_TOTAL(VT), .PCLK_DIV(PD)
    ) dut (
        .clk100     (clk100),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .ov_pclk    (ov_pclk),
        .ov_vsync   (ov_vsync),
        .ov_href    (ov_href),
        .ov_d       (ov_d),
        .frame_done (frame_done)
    );

    always #5 clk100 = ~clk100;

    int errors = 0;
    int checks = 0;

    // Receiver model: capture {vsync, href, d} on each rising PCLK, starting
    // with the first VSYNC-high sample, and close the frame on frame_done.
    logic [9:0] smp_q [$];
    int         frames [$];
    int         cap_cnt = 0;
    bit         cap_on = 0;
    bit         prev_pclk = 0;
    bit         prev_done = 0;
    int         done_cnt = 0;
    int         wide_done = 0;

    always @(negedge clk100) begin
        if (reset) begin
            cap_on    = 0;
            cap_cnt   = 0;
            prev_pclk = 0;
            prev_done = 0;
        end else begin
            if (ov_pclk && !prev_pclk) begin
                if (!cap_on && ov_vsync) cap_on = 1;
                if (cap_on) begin
                    smp_q.push_back({ov_vsync, ov_href, ov_d});
                    cap_cnt++;
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (prev_done) wide_done++;
                frames.push_back(cap_cnt);
                cap_cnt = 0;
                cap_on  = 0;
            end
            prev_pclk = ov_pclk;
            prev_done = frame_done;
        end
    end

    // Expected bus sample for slot idx of a frame, from the frame timing rules.
    function automatic logic [9:0] exp_smp(int m, logic [15:0] s, int idx);
        int line, slot, x, y;
        logic [15:0] pix;
        logic vs, hr;
        logic [7:0] b;
        line = idx / LINE_SLOTS;
        slot = idx % LINE_SLOTS;
        vs = (line < VS);
        hr = (line >= VS + VBP) && (line < VS + VBP + VA) && (slot < 2 * HA);
        if (!hr) return {vs, 1'b0, 8'h00};
        x = slot / 2;
        y = line - VS - VBP;
        case (m)
            1:       pix = 16'(x + y);
            2:       pix = s;
            default: pix = BARS[x / (HA / 8)];
        endcase
        b = (slot % 2 == 0) ? pix[15:8] : pix[7:0];
        return {vs, 1'b1, b};
    endfunction

    function automatic int count_bad(int m, logic [15:0] s, int off);
        int bad = 0;
        for (int i = 0; i < FRAME_SLOTS; i++) begin
            if (smp_q.size() <= off + i) bad++;
            else if (smp_q[off + i] !== exp_smp(m, s, i)) bad++;
        end
        return bad;
    endfunction

    function automatic logic [9:0] get_smp(int i);
        if (smp_q.size() > i) return smp_q[i];
        return 10'bx;
    endfunction

    function automatic int frame_len(int k);
        if (frames.size() > k) return frames[k];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk100);
        #2;
    endtask

    task automatic clear_capture();
        smp_q.delete();
        frames.delete();
        cap_cnt = 0;
    endtask

    task automatic wait_cap(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (cap_cnt >= n) begin ok = 1; break; end
            tick(1);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (frames.size() >= n) begin ok = 1; break; end
            tick(1);
        end
    endtask

    task automatic idle_highs(input int n, output int highs);
        highs = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (ov_pclk || ov_vsync || ov_href) highs++;
        end
    endtask

    // One frame; enable drops and inputs are scrambled once the frame is underway.
    task automatic run_single(input logic [1:0] m, input logic [15:0] s, output bit ok);
        bit ok1, ok2;
        clear_capture();
        mode      = m;
        solid_rgb = s;
        enable    = 1;
        wait_cap(1, 200, ok1);
        enable    = 0;
        mode      = 2'($urandom);
        solid_rgb = 16'($urandom);
        wait_frames(1, 2000, ok2);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        int highs;
        reset = 1;
        tick(3);
        checks++; if (ov_pclk !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b want 0", ov_pclk); end
        checks++; if (ov_vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", ov_vsync); end
        checks++; if (ov_href !== 1'b0) begin errors++; $display("FAIL reset_href: got %b want 0", ov_href); end
        checks++; if (ov_d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h want 00", ov_d); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        reset = 0;
        idle_highs(40, highs);
        checks++; if (highs !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles want 0", highs); end
    endtask

    task automatic test_solid();
        bit ok;
        int bad, highs;
        run_single(2'd2, 16'hABCD, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL solid_timeout: got %b want 1", ok); end
        checks++; if (frame_len(0) !== FRAME_SLOTS) begin errors++; $display("FAIL solid_len: got %0d want %0d", frame_len(0), FRAME_SLOTS); end
        bad = count_bad(2, 16'hABCD, 0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL solid_frame: got %0d bad slots want 0", bad); end
        checks++; if (get_smp(0) !== 10'h200) begin errors++; $display("FAIL solid_vsync: got %h want 200", get_smp(0)); end
        checks++; if (get_smp(20) !== 10'h000) begin errors++; $display("FAIL solid_vbp: got %h want 000", get_smp(20)); end
        checks++; if (get_smp(40) !== 10'h1AB) begin errors++; $display("FAIL solid_hi: got %h want 1ab", get_smp(40)); end
        checks++; if (get_smp(41) !== 10'h1CD) begin errors++; $display("FAIL solid_lo: got %h want 1cd", get_smp(41)); end
        checks++; if (get_smp(56) !== 10'h000) begin errors++; $display("FAIL solid_hblank: got %h want 000", get_smp(56)); end
        idle_highs(40, highs);
        checks++; if (highs !== 0) begin errors++; $display("FAIL solid_idle: got %0d active cycles want 0", highs); end
        checks++; if (frames.size() !== 1) begin errors++; $display("FAIL solid_done_count: got %0d want 1", frames.size()); end
    endtask

    task automatic test_bars();
        bit ok;
        int bad;
        run_single(2'd0, 16'h1234, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bars_timeout: got %b want 1", ok); end
        bad = count_bad(0, 16'h1234, 0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL bars_frame: got %0d bad slots want 0", bad); end
        checks++; if (get_smp(43) !== 10'h1E0) begin errors++; $display("FAIL bars_yellow_lo: got %h want 1e0", get_smp(43)); end
        checks++; if (get_smp(68) !== 10'h1F8) begin errors++; $display("FAIL bars_magenta_hi: got %h want 1f8", get_smp(68)); end
        run_single(2'd3, 16'h5555, ok);
        bad = count_bad(3, 16'h5555, 0);
        checks++; if (!ok || bad !== 0) begin errors++; $display("FAIL bars_mode3: got ok=%b bad=%0d want ok=1 bad=0", ok, bad); end
    endtask

    task automatic test_gradient();
        bit ok;
        int bad;
        run_single(2'd1, 16'hFFFF, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL grad_timeout: got %b want 1", ok); end
        bad = count_bad(1, 16'hFFFF, 0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL grad_frame: got %0d bad slots want 0", bad); end
        checks++; if (get_smp(55) !== 10'h107) begin errors++; $display("FAIL grad_l0_last: got %h want 107", get_smp(55)); end
        checks++; if (get_smp(61) !== 10'h101) begin errors++; $display("FAIL grad_l1_first: got %h want 101", get_smp(61)); end
        checks++; if (get_smp(75) !== 10'h108) begin errors++; $display("FAIL grad_l1_last: got %h want 108", get_smp(75)); end
    endtask

    task automatic test_enable_drop();
        bit ok1, ok2;
        int bad, highs, d0;
        logic [15:0] s;
        s = 16'($urandom);
        clear_capture();
        d0 = done_cnt;
        mode = 2'd2; solid_rgb = s; enable = 1;
        wait_cap(65, 1000, ok1);
        enable = 0;
        wait_frames(1, 2000, ok2);
        idle_highs(60, highs);
        checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL drop_timeout: got %b%b want 11", ok1, ok2); end
        checks++; if (frame_len(0) !== FRAME_SLOTS) begin errors++; $display("FAIL drop_len: got %0d want %0d", frame_len(0), FRAME_SLOTS); end
        bad = count_bad(2, s, 0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL drop_frame: got %0d bad slots want 0", bad); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL drop_done_once: got %0d want 1", done_cnt - d0); end
        checks++; if (highs !== 0 || ov_pclk !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0d active pclk=%b want 0", highs, ov_pclk); end
    endtask

    task automatic test_reset_mid();
        bit ok, found, ok2;
        bit prev_p;
        int falls, d0, bad;
        logic [15:0] s;
        s = 16'($urandom) | 16'h0101;
        clear_capture();
        mode = 2'd2; solid_rgb = s; enable = 1;
        wait_cap(45, 1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_timeout: got %b want 1", ok); end
        d0 = done_cnt;
        reset = 1;
        #1;
        checks++; if (ov_href !== 1'b0 || ov_d !== 8'h00) begin errors++; $display("FAIL rmid_bus: got href=%b d=%h want 0 00", ov_href, ov_d); end
        checks++; if (ov_pclk !== 1'b0 || ov_vsync !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got pclk=%b vs=%b done=%b want 000", ov_pclk, ov_vsync, frame_done); end
        tick(3);
        clear_capture();
        reset = 0;
        falls = 0; found = 0; prev_p = 0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (prev_p && !ov_pclk) falls++;
            if (ov_vsync) begin found = 1; break; end
            prev_p = ov_pclk;
        end
        checks++; if (!found || falls !== 1 || ov_pclk !== 1'b0) begin errors++; $display("FAIL rmid_vsync_first_fall: got found=%b falls=%0d pclk=%b want 1 1 0", found, falls, ov_pclk); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rmid_no_done: got %0d want %0d", done_cnt, d0); end
        enable = 0;
        wait_frames(1, 2000, ok2);
        bad = count_bad(2, s, 0);
        checks++; if (!ok2 || bad !== 0) begin errors++; $display("FAIL rmid_next_frame: got ok=%b bad=%0d want 1 0", ok2, bad); end
        tick(20);
    endtask

    task automatic test_mode_change();
        bit ok1, ok2, ok3, ok4;
        int bad1, bad2;
        logic [15:0] s1, s2;
        s1 = 16'($urandom); s2 = 16'($urandom);
        clear_capture();
        mode = 2'd0; solid_rgb = s1; enable = 1;
        wait_cap(50, 1000, ok1);
        mode = 2'd2; solid_rgb = s2;
        wait_frames(1, 2000, ok2);
        wait_cap(10, 1000, ok3);
        enable = 0;
        wait_frames(2, 2000, ok4);
        checks++; if (!(ok1 && ok2 && ok3 && ok4)) begin errors++; $display("FAIL mchg_timeout: got %b%b%b%b want 1111", ok1, ok2, ok3, ok4); end
        checks++; if (frame_len(0) !== FRAME_SLOTS || frame_len(1) !== FRAME_SLOTS) begin errors++; $display("FAIL mchg_len: got %0d %0d want %0d", frame_len(0), frame_len(1), FRAME_SLOTS); end
        bad1 = count_bad(0, s1, 0);
        bad2 = count_bad(2, s2, FRAME_SLOTS);
        checks++; if (bad1 !== 0) begin errors++; $display("FAIL mchg_bars_kept: got %0d bad slots want 0", bad1); end
        checks++; if (bad2 !== 0) begin errors++; $display("FAIL mchg_solid_next: got %0d bad slots want 0", bad2); end
        tick(20);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3, ok4;
        int bad;
        logic [1:0]  m [3];
        logic [15:0] s [3];
        for (int k = 0; k < 3; k++) begin
            m[k] = 2'($urandom);
            s[k] = 16'($urandom);
        end
        clear_capture();
        mode = m[0]; solid_rgb = s[0]; enable = 1;
        wait_cap(1, 200, ok1);
        mode = m[1]; solid_rgb = s[1];
        wait_frames(1, 2000, ok2);
        mode = m[2]; solid_rgb = s[2];
        wait_frames(2, 2000, ok3);
        enable = 0;
        mode = 2'($urandom); solid_rgb = 16'($urandom);
        wait_frames(3, 2000, ok4);
        checks++; if (!(ok1 && ok2 && ok3 && ok4) || frames.size() !== 3) begin errors++; $display("FAIL b2b_frames: got %0d frames want 3", frames.size()); end
        for (int k = 0; k < 3; k++) begin
            bad = count_bad(m[k], s[k], k * FRAME_SLOTS);
            checks++; if (bad !== 0 || frame_len(k) !== FRAME_SLOTS) begin errors++; $display("FAIL b2b_frame%0d: got bad=%0d len=%0d want 0 %0d", k, bad, frame_len(k), FRAME_SLOTS); end
        end
        checks++; if (wide_done !== 0) begin errors++; $display("FAIL done_width: got %0d wide pulses want 0", wide_done); end
        tick(20);
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_gradient();
        test_enable_drop();
        test_reset_mid();
        test_mode_change();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
